// File: rtl/mem_req_sequencer.sv
// mem_req_sequencer
//   Turns one cache memory request (line fill or write-back) into a single
//   strobe toward the memory request FIFO. For fills it then waits for the
//   read response, with a bounded wait. Completion is reported to the cache
//   with a one-cycle resp_ready pulse.
//
// Parameters
//   ADDR_W   DRAM line address width
//   LINE_W   cache line width
//   TIMEOUT  maximum number of cycles to wait for a read response
//
// Ports
//   sys_clk, rst      clock, synchronous active-high reset
//   req_valid         cache request pending (held until serviced)
//   req_rw            1 = write-back, 0 = line fill
//   req_addr/data     request line address / write data
//   resp_data         fill data of the most recent read (0 after a timeout)
//   resp_ready        one-cycle completion pulse
//   fifo_req_en       one-cycle request strobe toward the FIFO
//   fifo_req_cmd      1 = read, 0 = write
//   fifo_req_addr     request address
//   fifo_req_data     request write data
//   fifo_req_rdy      FIFO accepts a strobe this cycle
//   fifo_rsp_en       read response valid
//   fifo_rsp_data     read response data
//   fifo_rsp_rdy      always 1, responses are never stalled
//   busy              FSM is not in IDLE
//   timeout_err       sticky, a read timed out
//   stray_rsp         sticky, a response arrived while no read was outstanding

module mem_req_sequencer #(
  parameter int ADDR_W  = 27,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_data,
  output logic [LINE_W-1:0] resp_data,
  output logic              resp_ready,
  output logic              fifo_req_en,
  output logic              fifo_req_cmd,
  output logic [ADDR_W-1:0] fifo_req_addr,
  output logic [LINE_W-1:0] fifo_req_data,
  input  logic              fifo_req_rdy,
  input  logic              fifo_rsp_en,
  input  logic [LINE_W-1:0] fifo_rsp_data,
  output logic              fifo_rsp_rdy,
  output logic              busy,
  output logic              timeout_err,
  output logic              stray_rsp
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_t;

  state_t            state;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] data_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  cnt_next;

  // The counter holds the number of wait cycles already spent without a
  // response. Timeout fires in the wait cycle that would bring it to
  // TIMEOUT, so the counter never needs to exceed TIMEOUT and cannot wrap.
  assign cnt_next = wait_cnt + CNT_W'(1);

  // Main FSM. resp_ready is registered on the way out of DONE, so it is
  // high in the first IDLE cycle after completion. That same cycle is the
  // mandatory IDLE gap: a req_valid the cache has not dropped yet is not
  // taken as a new request.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state       <= IDLE;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      wait_cnt    <= '0;
      resp_data   <= '0;
      resp_ready  <= 1'b0;
      timeout_err <= 1'b0;
      stray_rsp   <= 1'b0;
    end else begin
      resp_ready <= 1'b0;

      // Responses outside WAIT_RSP are only flagged, never consumed.
      if (fifo_rsp_en && (state != WAIT_RSP)) begin
        stray_rsp <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (req_valid && !resp_ready) begin
            rw_q   <= req_rw;
            addr_q <= req_addr;
            data_q <= req_data;
            state  <= ISSUE;
          end
        end

        ISSUE: begin
          if (fifo_req_rdy) begin
            if (rw_q) begin
              state <= DONE;
            end else begin
              wait_cnt <= '0;
              state    <= WAIT_RSP;
            end
          end
        end

        WAIT_RSP: begin
          // A response in the final wait cycle takes priority over the timeout.
          if (fifo_rsp_en) begin
            resp_data <= fifo_rsp_data;
            state     <= DONE;
          end else if (cnt_next == TIMEOUT_C) begin
            wait_cnt    <= cnt_next;
            timeout_err <= 1'b1;
            resp_data   <= '0;
            state       <= DONE;
          end else begin
            wait_cnt <= cnt_next;
          end
        end

        DONE: begin
          resp_ready <= 1'b1;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // The strobe follows fifo_req_rdy directly while in ISSUE. The FSM leaves
  // ISSUE on the first accepted cycle, so the strobe lasts one cycle per request.
  assign fifo_req_en   = (state == ISSUE) && fifo_req_rdy;
  assign fifo_req_cmd  = ~rw_q;
  assign fifo_req_addr = addr_q;
  assign fifo_req_data = data_q;
  assign fifo_rsp_rdy  = 1'b1;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Testbench for mem_req_sequencer.
// Two instances share all inputs. dut uses the default TIMEOUT, and dut_b
// uses TIMEOUT=8 for the timeout cases. Inputs change 1ns after a rising
// edge. Strobe and completion events are logged on the falling edge.
module tb_mem_req_sequencer;

  localparam int ADDR_W = 27;
  localparam int LINE_W = 128;

  localparam logic [LINE_W-1:0] WR_DATA = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [LINE_W-1:0] RD1     = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [LINE_W-1:0] RD2     = 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F;
  localparam logic [LINE_W-1:0] BP_DATA = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  logic              sys_clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_rw = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LINE_W-1:0] req_data = '0;
  logic              fifo_req_rdy = 1'b1;
  logic              fifo_rsp_en = 1'b0;
  logic [LINE_W-1:0] fifo_rsp_data = '0;

  logic [LINE_W-1:0] resp_data, resp_data_b;
  logic              resp_ready, resp_ready_b;
  logic              fifo_req_en, fifo_req_en_b;
  logic              fifo_req_cmd, fifo_req_cmd_b;
  logic [ADDR_W-1:0] fifo_req_addr, fifo_req_addr_b;
  logic [LINE_W-1:0] fifo_req_data, fifo_req_data_b;
  logic              fifo_rsp_rdy, fifo_rsp_rdy_b;
  logic              busy, busy_b;
  logic              timeout_err, timeout_err_b;
  logic              stray_rsp, stray_rsp_b;

  mem_req_sequencer dut (
    .sys_clk(sys_clk), .rst(rst),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .resp_data(resp_data), .resp_ready(resp_ready),
    .fifo_req_en(fifo_req_en), .fifo_req_cmd(fifo_req_cmd),
    .fifo_req_addr(fifo_req_addr), .fifo_req_data(fifo_req_data),
    .fifo_req_rdy(fifo_req_rdy), .fifo_rsp_en(fifo_rsp_en),
    .fifo_rsp_data(fifo_rsp_data), .fifo_rsp_rdy(fifo_rsp_rdy),
    .busy(busy), .timeout_err(timeout_err), .stray_rsp(stray_rsp)
  );

  mem_req_sequencer #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(8)) dut_b (
    .sys_clk(sys_clk), .rst(rst),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .resp_data(resp_data_b), .resp_ready(resp_ready_b),
    .fifo_req_en(fifo_req_en_b), .fifo_req_cmd(fifo_req_cmd_b),
    .fifo_req_addr(fifo_req_addr_b), .fifo_req_data(fifo_req_data_b),
    .fifo_req_rdy(fifo_req_rdy), .fifo_rsp_en(fifo_rsp_en),
    .fifo_rsp_data(fifo_rsp_data), .fifo_rsp_rdy(fifo_rsp_rdy_b),
    .busy(busy_b), .timeout_err(timeout_err_b), .stray_rsp(stray_rsp_b)
  );

  always #5 sys_clk = ~sys_clk;

  // Cycle index: it equals k during the cycle that starts at the k-th rising edge.
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Event log. Each strobe and completion pulse is recorded with its
  // cycle index and the request fields seen on the FIFO side.
  int                strobe_cnt = 0, strobe_cyc = 0, strobe_b_cnt = 0, strobe_b_cyc = 0;
  int                ready_cnt = 0, ready_cyc = 0, ready_b_cnt = 0, ready_b_cyc = 0;
  logic              strobe_cmd = 1'b0, strobe_b_cmd = 1'b0;
  logic [ADDR_W-1:0] strobe_addr = '0, strobe_b_addr = '0;
  logic [LINE_W-1:0] strobe_data = '0, strobe_b_data = '0;

  always @(negedge sys_clk) begin
    if (fifo_req_en) begin
      strobe_cnt++;
      strobe_cyc  = cyc;
      strobe_cmd  = fifo_req_cmd;
      strobe_addr = fifo_req_addr;
      strobe_data = fifo_req_data;
    end
    if (fifo_req_en_b) begin
      strobe_b_cnt++;
      strobe_b_cyc  = cyc;
      strobe_b_cmd  = fifo_req_cmd_b;
      strobe_b_addr = fifo_req_addr_b;
      strobe_b_data = fifo_req_data_b;
    end
    if (resp_ready) begin
      ready_cnt++;
      ready_cyc = cyc;
    end
    if (resp_ready_b) begin
      ready_b_cnt++;
      ready_b_cyc = cyc;
    end
  end

  int checks = 0;
  int errors = 0;
  int rise = 0;
  int s_base = 0, sb_base = 0, r_base = 0, rb_base = 0;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Raises a request and records the rise cycle and the event counts at that point.
  task automatic applyStimulus(input logic rw, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data);
    req_rw    = rw;
    req_addr  = addr;
    req_data  = data;
    req_valid = 1'b1;
    rise      = cyc;
    s_base    = strobe_cnt;
    sb_base   = strobe_b_cnt;
    r_base    = ready_cnt;
    rb_base   = ready_b_cnt;
  endtask

  task automatic waitStrobe(input bit use_b, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = use_b ? (strobe_b_cnt > sb_base) : (strobe_cnt > s_base);
    end
    checkOutput(use_b ? "strobe_seen_b" : "strobe_seen", 128'(seen), 128'd1);
  endtask

  task automatic waitReady(input bit use_b, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = use_b ? (ready_b_cnt > rb_base) : (ready_cnt > r_base);
    end
    checkOutput(use_b ? "ready_seen_b" : "ready_seen", 128'(seen), 128'd1);
  endtask

  // Steps forward until the cycle index reaches target, with a bounded number of steps.
  task automatic waitCycle(input int target);
    for (int i = 0; i < 100 && cyc < target; i++) tick();
  endtask

  initial begin
    int rc;

    // Reset state while rst is held.
    repeat (3) tick();
    checkOutput("rst_busy", 128'(busy), 128'd0);
    checkOutput("rst_resp_ready", 128'(resp_ready), 128'd0);
    checkOutput("rst_fifo_req_en", 128'(fifo_req_en), 128'd0);
    checkOutput("rst_resp_data", resp_data, 128'd0);
    checkOutput("rst_timeout_err", 128'(timeout_err), 128'd0);
    checkOutput("rst_stray", 128'(stray_rsp), 128'd0);
    checkOutput("rst_rsp_rdy", 128'(fifo_rsp_rdy), 128'd1);
    checkOutput("rst_rsp_rdy_b", 128'(fifo_rsp_rdy_b), 128'd1);
    checkOutput("rst_busy_b", 128'(busy_b), 128'd0);
    checkOutput("rst_stray_b", 128'(stray_rsp_b), 128'd0);
    rst = 1'b0;
    tick();

    // Write-back: one strobe, cmd=0, ready 3 cycles after req_valid.
    // req_valid is still high in the ready cycle and must not be re-issued.
    fifo_req_rdy = 1'b1;
    applyStimulus(1'b1, 27'h0001230, WR_DATA);
    waitReady(1'b0, 20);
    req_valid = 1'b0;
    repeat (4) tick();
    checkOutput("wr_strobe_count", 128'(strobe_cnt), 128'(s_base + 1));
    checkOutput("wr_cmd", 128'(strobe_cmd), 128'd0);
    checkOutput("wr_addr", 128'(strobe_addr), 128'h0001230);
    checkOutput("wr_data", strobe_data, WR_DATA);
    checkOutput("wr_latency", 128'(ready_cyc - rise), 128'd3);
    checkOutput("wr_ready_count", 128'(ready_cnt), 128'(r_base + 1));
    checkOutput("wr_resp_data_kept", resp_data, 128'd0);

    // Line fill with the response 10 cycles after the strobe: ready on cycle 13.
    applyStimulus(1'b0, 27'h0004560, '0);
    waitStrobe(1'b0, 10);
    waitCycle(strobe_cyc + 10);
    fifo_rsp_en   = 1'b1;
    fifo_rsp_data = RD1;
    tick();
    fifo_rsp_en   = 1'b0;
    fifo_rsp_data = '0;
    waitReady(1'b0, 20);
    req_valid = 1'b0;
    tick();
    checkOutput("rd_cmd", 128'(strobe_cmd), 128'd1);
    checkOutput("rd_addr", 128'(strobe_addr), 128'h0004560);
    checkOutput("rd_strobe_cycle", 128'(strobe_cyc - rise), 128'd1);
    checkOutput("rd_latency", 128'(ready_cyc - rise), 128'd13);
    checkOutput("rd_resp_data", resp_data, RD1);
    checkOutput("rd_timeout_err", 128'(timeout_err), 128'd0);
    checkOutput("rd_stray", 128'(stray_rsp), 128'd0);

    // Backpressure: rdy low for 5 ISSUE cycles. Request inputs change
    // after acceptance and must be ignored.
    fifo_req_rdy = 1'b0;
    applyStimulus(1'b1, 27'h00ABCDE, BP_DATA);
    repeat (3) tick();
    checkOutput("bp_busy", 128'(busy), 128'd1);
    checkOutput("bp_no_strobe", 128'(fifo_req_en), 128'd0);
    req_addr = 27'h7FFFFFF;
    req_data = '1;
    repeat (3) tick();
    fifo_req_rdy = 1'b1;
    waitReady(1'b0, 20);
    req_valid = 1'b0;
    repeat (3) tick();
    checkOutput("bp_strobe_count", 128'(strobe_cnt), 128'(s_base + 1));
    checkOutput("bp_strobe_cycle", 128'(strobe_cyc - rise), 128'd6);
    checkOutput("bp_addr", 128'(strobe_addr), 128'h00ABCDE);
    checkOutput("bp_data", strobe_data, BP_DATA);
    checkOutput("bp_latency", 128'(ready_cyc - rise), 128'd8);
    checkOutput("bp_resp_data_kept", resp_data, RD1);

    // Stray response in IDLE.
    rc = ready_cnt;
    fifo_rsp_en   = 1'b1;
    fifo_rsp_data = RD2;
    tick();
    fifo_rsp_en   = 1'b0;
    fifo_rsp_data = '0;
    checkOutput("stray_set", 128'(stray_rsp), 128'd1);
    checkOutput("stray_busy", 128'(busy), 128'd0);
    checkOutput("stray_resp_data", resp_data, RD1);
    tick();
    checkOutput("stray_no_ready", 128'(ready_cnt), 128'(rc));

    // Reset during WAIT_RSP, then a late response.
    applyStimulus(1'b0, 27'h0000777, '0);
    waitStrobe(1'b0, 10);
    req_valid = 1'b0;
    repeat (2) tick();
    checkOutput("mid_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_busy", 128'(busy), 128'd0);
    checkOutput("mid_rst_resp_ready", 128'(resp_ready), 128'd0);
    checkOutput("mid_rst_req_en", 128'(fifo_req_en), 128'd0);
    checkOutput("mid_rst_resp_data", resp_data, 128'd0);
    checkOutput("mid_rst_stray", 128'(stray_rsp), 128'd0);
    checkOutput("mid_rst_rsp_rdy", 128'(fifo_rsp_rdy), 128'd1);
    rst = 1'b0;
    rc  = ready_cnt;
    tick();
    fifo_rsp_en   = 1'b1;
    fifo_rsp_data = RD2;
    tick();
    fifo_rsp_en   = 1'b0;
    fifo_rsp_data = '0;
    repeat (3) tick();
    checkOutput("late_stray", 128'(stray_rsp), 128'd1);
    checkOutput("late_resp_data", resp_data, 128'd0);
    checkOutput("late_busy", 128'(busy), 128'd0);
    checkOutput("late_timeout", 128'(timeout_err), 128'd0);
    checkOutput("late_no_ready", 128'(ready_cnt), 128'(rc));

    // TIMEOUT=8 instance. A response in the 8th wait cycle is accepted.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(1'b0, 27'h0000888, '0);
    waitStrobe(1'b1, 10);
    waitCycle(strobe_b_cyc + 8);
    fifo_rsp_en   = 1'b1;
    fifo_rsp_data = RD2;
    tick();
    fifo_rsp_en   = 1'b0;
    fifo_rsp_data = '0;
    waitReady(1'b1, 20);
    req_valid = 1'b0;
    tick();
    checkOutput("edge_cmd_b", 128'(strobe_b_cmd), 128'd1);
    checkOutput("edge_addr_b", 128'(strobe_b_addr), 128'h0000888);
    checkOutput("edge_timeout_b", 128'(timeout_err_b), 128'd0);
    checkOutput("edge_resp_data_b", resp_data_b, RD2);
    checkOutput("edge_latency_b", 128'(ready_b_cyc - rise), 128'd11);

    // No response: timeout after 8 wait cycles, resp_data cleared.
    applyStimulus(1'b0, 27'h0000999, '0);
    waitReady(1'b1, 30);
    req_valid = 1'b0;
    tick();
    checkOutput("to_latency_b", 128'(ready_b_cyc - rise), 128'd11);
    checkOutput("to_resp_data_b", resp_data_b, 128'd0);
    checkOutput("to_timeout_b", 128'(timeout_err_b), 128'd1);
    checkOutput("to_dflt_not_timed_out", 128'(timeout_err), 128'd0);

    // timeout_err remains set through a following write.
    applyStimulus(1'b1, 27'h0000ABC, WR_DATA);
    waitReady(1'b1, 20);
    req_valid = 1'b0;
    tick();
    checkOutput("sticky_wr_cmd_b", 128'(strobe_b_cmd), 128'd0);
    checkOutput("sticky_wr_data_b", strobe_b_data, WR_DATA);
    checkOutput("sticky_timeout_b", 128'(timeout_err_b), 128'd1);
    checkOutput("sticky_resp_data_b", resp_data_b, 128'd0);
    checkOutput("sticky_stray_b", 128'(stray_rsp_b), 128'd0);
    checkOutput("sticky_busy_b", 128'(busy_b), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_req_sequencer.md
MEM_REQ_SEQUENCER -- requirements
Module: mem_req_sequencer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- ADDR_W, 27, DRAM address width.
- LINE_W, 128, cache line width.
- TIMEOUT, 1023, maximum wait cycles for a read response.

REQ-002 Clock and reset SHALL be one clock, with a synchronous, active-high reset. Ports:
- sys_clk  in  1  clock.
- rst  in  1  synchronous active-high reset.

REQ-003 Cache-side ports SHALL be:
- req_valid  in  1  cache memory request pending; held high until serviced.
- req_rw  in  1  1 = write-back, 0 = line fill.
- req_addr  in  ADDR_W  line address.
- req_data  in  LINE_W  write data.
- resp_data  out  LINE_W  fill data.
- resp_ready  out  1  one-cycle completion pulse.

REQ-004 FIFO-side ports SHALL be:
- fifo_req_en  out  1  one-cycle request strobe.
- fifo_req_cmd  out  1  ~req_rw (1 = read, 0 = write).
- fifo_req_addr  out  ADDR_W  address.
- fifo_req_data  out  LINE_W  write data.
- fifo_req_rdy  in  1  FIFO accepts a strobe this cycle.
- fifo_rsp_en  in  1  read response valid.
- fifo_rsp_data  in  LINE_W  read data.
- fifo_rsp_rdy  out  1  constant 1.

REQ-005 Status ports SHALL be:
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky; set when a read times out.
- stray_rsp  out  1  sticky; set by fifo_rsp_en outside WAIT_RSP.

Function
REQ-006 The FSM SHALL have four states: IDLE, ISSUE, WAIT_RSP, DONE.

REQ-007 IDLE with req_valid=1: the block SHALL register req_rw/addr/data and go to ISSUE next cycle. Later changes on the req_* inputs SHALL be ignored until return to IDLE.

REQ-008 ISSUE: fifo_req_en SHALL equal fifo_req_rdy, driven from the registered copies. With fifo_req_rdy=0 the block SHALL stay in ISSUE, retrying every cycle.

REQ-009 ISSUE with fifo_req_rdy=1:
- write: go to DONE.
- read: go to WAIT_RSP and clear the timeout counter.

REQ-010 fifo_req_en SHALL never be high for more than one cycle per accepted request, and SHALL be high in no other state.

REQ-011 WAIT_RSP with fifo_rsp_en=1: the block SHALL capture fifo_rsp_data into resp_data and go to DONE.

REQ-012 WAIT_RSP timeout handling:
- the counter SHALL increment each cycle without a response;
- when the counter equals TIMEOUT, the block SHALL set timeout_err, load resp_data=0 and go to DONE;
- if fifo_rsp_en=1 in the same cycle the counter reaches TIMEOUT, the response SHALL win and timeout_err SHALL NOT be set.

REQ-013 DONE SHALL assert resp_ready for exactly one cycle, then return to IDLE.

REQ-014 After DONE the block SHALL spend at least one cycle in IDLE before accepting a new request, so a still-high req_valid is not re-issued. Min request-to-request spacing: write 4 cycles, read 5 cycles plus response latency.

REQ-015 Latency from req_valid rise (IDLE, fifo_req_rdy=1) to resp_ready:
- write: 3 cycles.
- read: 3 cycles plus the response delay, counted from the fifo_req_en cycle to the fifo_rsp_en cycle.

REQ-016 resp_data SHALL hold its value until the next read completes; writes SHALL NOT modify it.

REQ-017 fifo_rsp_en in IDLE, ISSUE or DONE SHALL set stray_rsp, SHALL be discarded, and SHALL NOT alter state or resp_data.

REQ-018 The timeout counter SHALL be wide enough for TIMEOUT and SHALL NOT wrap.

Reset
REQ-019 When rst=1 at a clock edge, from any state, the block SHALL:
- go to IDLE;
- set resp_ready=0, fifo_req_en=0, resp_data=0, busy=0;
- clear timeout_err, stray_rsp, the counter and all registered request fields.

REQ-020 Reset during WAIT_RSP SHALL abandon the read. A response arriving after reset SHALL set stray_rsp only.

REQ-021 fifo_rsp_rdy SHALL be 1 during and after reset.

Verification
REQ-022 Write: req_valid=1, rw=1, addr=0x0001230, data=0xDEADBEEF_... with fifo_req_rdy=1 -> single fifo_req_en, cmd=0, addr/data matching; resp_ready exactly 3 cycles after req_valid; no second strobe while req_valid is held 2 more cycles.

REQ-023 Read: rw=0, addr=0x0004560, response 10 cycles after strobe with data=0x0123_4567_89AB_CDEF_0011_2233_4455_6677 -> cmd=1, resp_data equals that value, resp_ready on cycle 13.

REQ-024 Backpressure: fifo_req_rdy=0 for 5 cycles, then 1 -> exactly one fifo_req_en, in the first rdy cycle.

REQ-025 Timeout: TIMEOUT=8, no response -> resp_ready with resp_data=0 and timeout_err=1 sticky. Response on exactly the 8th wait cycle -> data accepted, timeout_err=0.

REQ-026 Stray and reset: fifo_rsp_en pulse in IDLE -> stray_rsp=1, state unchanged. rst asserted mid-WAIT_RSP -> all outputs zero next cycle; a late response sets only stray_rsp.
